zm_vca_multi: RTL and testbench

//  Multi-channel signed VCA for the i2s synth voice path. Multiplies CHANNELS

---
 rtl/zm_audio_pkg.sv | 24 ++
 rtl/zm_smul.sv | 37 +++
 rtl/zm_vca_multi.sv | 178 +++++++++++++++++
 tb/tb_zm_vca_multi.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zm_audio_pkg.sv
// Shared definitions for the audio voice-path blocks.
// Samples are signed two's complement. Gains are signed Q1.(GAIN_W-1), so the
// largest positive gain (0x7FFF at 16 bits) sits just below unity and the most
// negative gain (0x8000) is exactly -1.0.
// Contents: VCA sequencing state encoding, saturation bound helpers.
package zm_audio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } vca_state_t;

    // Largest / smallest value representable in a w-bit signed word.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/zm_smul.sv
// Pipelined signed multiplier, A_W x B_W -> A_W+B_W, LAT register stages.
// The product is registered at the first stage and then delayed, which lets
// the tools fold it into an SB_MAC16 when both operands are 16 bits or less;
// wider operands fall back to inferred logic.
// Ports:
//   clk, rst  clock, async active-high reset (clears the pipeline)
//   a_i       signed operand A
//   b_i       signed operand B
//   p_o       signed full-width product, LAT cycles after the operands
module zm_smul #(
    parameter int A_W = 16,
    parameter int B_W = 16,
    parameter int LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [A_W-1:0]      a_i,
    input  logic signed [B_W-1:0]      b_i,
    output logic signed [A_W+B_W-1:0]  p_o
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0] pipe_q [LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= P_W'(a_i) * P_W'(b_i);
            for (int k = 1; k < LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    assign p_o = pipe_q[LAT-1];

endmodule

// File: rtl/zm_vca_multi.sv
// Multi-channel signed VCA. One frame of CHANNELS samples and target gains is
// accepted while idle; channels are issued one per cycle through a single
// shared multiplier, each gain slewing toward its target by
// (target-g)>>>SLEW_SHIFT per frame. Results are floor-scaled by 2^(GAIN_W-1),
// saturated, collected in a shadow register and published together with a
// one-cycle out_valid pulse.
// Ports:
//   clk, rst     clock, async active-high reset
//   in_valid     frame present on in_sample/in_gain
//   in_ready     idle, a frame will be accepted
//   in_sample    signed samples, channel c at [c*WIDTH +: WIDTH]
//   in_gain      signed target gains, channel c at [c*GAIN_W +: GAIN_W]
//   out_valid    one-cycle pulse, out_sample/sat_flags just updated
//   out_sample   saturated results, same packing as in_sample
//   sat_flags    bit c set when channel c clipped in the last frame
//
// state    | meaning
// ST_IDLE  | waiting for a frame, in_ready high
// ST_ISSUE | one channel per cycle into the multiplier, gain updated
// ST_DRAIN | waiting MUL_LAT cycles for the last product
// ST_DONE  | shadow copied to outputs, out_valid pulsed
module zm_vca_multi
    import zm_audio_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 16,
    parameter int GAIN_W     = 16,
    parameter int SLEW_SHIFT = 4,
    parameter int MUL_LAT    = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CHANNELS*WIDTH-1:0]  in_sample,
    input  logic [CHANNELS*GAIN_W-1:0] in_gain,
    output logic                       out_valid,
    output logic [CHANNELS*WIDTH-1:0]  out_sample,
    output logic [CHANNELS-1:0]        sat_flags
);

    localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int TW  = $clog2(MUL_LAT + 1);
    localparam int P_W = WIDTH + GAIN_W;
    localparam longint SMAX = sat_max(WIDTH);
    localparam longint SMIN = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SMAX_W = SMAX[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SMIN_W = SMIN[WIDTH-1:0];

    vca_state_t                  state_q;
    logic                        in_ready_q, out_valid_q;
    logic [CHANNELS*WIDTH-1:0]   out_sample_q, sh_s_q, smp_q;
    logic [CHANNELS-1:0]         sat_flags_q, sh_f_q;
    logic [CHANNELS*GAIN_W-1:0]  tgt_q;
    logic signed [GAIN_W-1:0]    g_q [CHANNELS];
    logic [CW-1:0]               cnt_q;
    logic [TW-1:0]               tmr_q;
    logic [MUL_LAT-1:0]          iv_q;
    logic [CW-1:0]               ich_q [MUL_LAT];

    logic                        issue;
    logic signed [WIDTH-1:0]     cur_smp;
    logic signed [GAIN_W-1:0]    cur_tgt, cur_g, g_d;
    logic signed [GAIN_W:0]      tgt_x, g_x, diff, step, gsum;
    logic signed [P_W-1:0]       prod, r_sh;
    longint                      r_l;
    logic [WIDTH-1:0]            res;
    logic                        clip;

    assign issue   = (state_q == ST_ISSUE);
    assign cur_smp = smp_q[cnt_q*WIDTH +: WIDTH];
    assign cur_tgt = tgt_q[cnt_q*GAIN_W +: GAIN_W];
    assign cur_g   = g_q[cnt_q];

    // One extra bit so target-g cannot overflow; the slewed gain always lies
    // between g and the target, so it fits back into GAIN_W bits.
    assign tgt_x = {cur_tgt[GAIN_W-1], cur_tgt};
    assign g_x   = {cur_g[GAIN_W-1], cur_g};
    assign diff  = tgt_x - g_x;
    assign step  = diff >>> SLEW_SHIFT;
    assign gsum  = g_x + step;
    assign g_d   = gsum[GAIN_W-1:0];

    zm_smul #(.A_W(WIDTH), .B_W(GAIN_W), .LAT(MUL_LAT)) u_smul (
        .clk (clk),
        .rst (rst),
        .a_i (cur_smp),
        .b_i (g_d),
        .p_o (prod)
    );

    assign r_sh = prod >>> (GAIN_W - 1);
    assign r_l  = longint'(r_sh);

    always_comb begin
        res  = r_sh[WIDTH-1:0];
        clip = 1'b0;
        if (r_l > SMAX) begin
            res  = SMAX_W;
            clip = 1'b1;
        end else if (r_l < SMIN) begin
            res  = SMIN_W;
            clip = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            sat_flags_q  <= '0;
            sh_s_q       <= '0;
            sh_f_q       <= '0;
            smp_q        <= '0;
            tgt_q        <= '0;
            cnt_q        <= '0;
            tmr_q        <= '0;
            iv_q         <= '0;
            for (int c = 0; c < CHANNELS; c++) g_q[c] <= '0;
            for (int k = 0; k < MUL_LAT; k++) ich_q[k] <= '0;
        end else begin
            out_valid_q <= 1'b0;

            // Channel tag travels alongside the multiplier pipeline.
            iv_q[0]  <= issue;
            ich_q[0] <= cnt_q;
            for (int k = 1; k < MUL_LAT; k++) begin
                iv_q[k]  <= iv_q[k-1];
                ich_q[k] <= ich_q[k-1];
            end
            if (iv_q[MUL_LAT-1]) begin
                sh_s_q[ich_q[MUL_LAT-1]*WIDTH +: WIDTH] <= res;
                sh_f_q[ich_q[MUL_LAT-1]]                <= clip;
            end

            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        smp_q      <= in_sample;
                        tgt_q      <= in_gain;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    g_q[cnt_q] <= g_d;
                    if (cnt_q == CW'(CHANNELS - 1)) begin
                        tmr_q   <= TW'(MUL_LAT - 1);
                        state_q <= ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (tmr_q == '0) state_q <= ST_DONE;
                    else             tmr_q   <= tmr_q - 1'b1;
                end
                ST_DONE: begin
                    out_sample_q <= sh_s_q;
                    sat_flags_q  <= sh_f_q;
                    out_valid_q  <= 1'b1;
                    in_ready_q   <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign sat_flags  = sat_flags_q;

endmodule

// File: tb/tb_zm_vca_multi.sv
// Bench for zm_vca_multi. Three instances share the same stimulus and differ
// only in SLEW_SHIFT (0, 2, 4); an arithmetic reference model tracks the
// smoothed gain of every channel of every instance.
module tb_zm_vca_multi;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int GW = 16;
    localparam int ML = 2;
    localparam int NI = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [CH*W-1:0]     in_sample;
    logic [CH*GW-1:0]    in_gain;
    logic                ir [NI];
    logic                ov [NI];
    logic [CH*W-1:0]     os [NI];
    logic [CH-1:0]       sf [NI];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        zm_vca_multi #(
            .CHANNELS(CH), .WIDTH(W), .GAIN_W(GW),
            .SLEW_SHIFT(2*k), .MUL_LAT(ML)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_ready   (ir[k]),
            .in_sample  (in_sample),
            .in_gain    (in_gain),
            .out_valid  (ov[k]),
            .out_sample (os[k]),
            .sat_flags  (sf[k])
        );
    end

    int tests = 0;
    int fails = 0;
    int gm [NI][CH];
    int es [NI][CH];
    bit ef [NI][CH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: g moves by floor((target-g)/2^shift); product floor-divided by 2^15.
    task automatic model_frame();
        int s, t;
        longint p, r;
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < CH; c++) begin
                s = int'($signed(in_sample[c*W +: W]));
                t = int'($signed(in_gain[c*GW +: GW]));
                gm[k][c] = gm[k][c] + ((t - gm[k][c]) >>> (2*k));
                p = longint'(s) * longint'(gm[k][c]);
                r = p >>> 15;
                ef[k][c] = 1'b0;
                if (r > 32767) begin
                    r = 32767; ef[k][c] = 1'b1;
                end else if (r < -32768) begin
                    r = -32768; ef[k][c] = 1'b1;
                end
                es[k][c] = int'(r);
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++)
            for (int c = 0; c < CH; c++) gm[k][c] = 0;
    endtask

    task automatic check_out(input string tag);
        for (int k = 0; k < NI; k++) begin
            for (int c = 0; c < CH; c++) begin
                check($sformatf("%s_i%0d_c%0d", tag, k, c),
                      64'(os[k][c*W +: W]), 64'(es[k][c] & 32'hFFFF));
                check($sformatf("%s_flag_i%0d_c%0d", tag, k, c),
                      64'(sf[k][c]), 64'(ef[k][c]));
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s_ready_i%0d", tag, k), 64'(ir[k]), 64'd1);
            check($sformatf("%s_valid_i%0d", tag, k), 64'(ov[k]), 64'd0);
            check($sformatf("%s_sample_i%0d", tag, k), 64'(os[k]), 64'd0);
            check($sformatf("%s_flags_i%0d", tag, k), 64'(sf[k]), 64'd0);
        end
    endtask

    task automatic randomize_frame();
        for (int c = 0; c < CH; c++) begin
            in_sample[c*W +: W]  = W'($urandom);
            in_gain[c*GW +: GW]  = GW'($urandom);
        end
    endtask

    // Present one frame, expect out_valid 7 cycles after acceptance, busy meanwhile.
    task automatic run_frame(input string tag);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        check({tag, "_ready"}, 64'(ir[0]), 64'd1);
        @(posedge clk);
        model_frame();
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ov[0]) begin
                lat = i;
                break;
            end
            if (i < 7) check({tag, "_busy"}, 64'(ir[0]), 64'd0);
        end
        check({tag, "_latency"}, 64'(lat), 64'd7);
        check({tag, "_ready_back"}, 64'(ir[0]), 64'd1);
        check({tag, "_valid_i1"}, 64'(ov[1]), 64'd1);
        check({tag, "_valid_i2"}, 64'(ov[2]), 64'd1);
        check_out(tag);
        @(posedge clk);
        #1 check({tag, "_pulse"}, 64'(ov[0]), 64'd0);
    endtask

    logic [15:0] slew_out [3];
    int acc, nov, last_acc, quiet;

    initial begin
        slew_out[0] = 16'h0FFF;
        slew_out[1] = 16'h1BFF;
        slew_out[2] = 16'h24FF;
        rst = 1'b1;
        in_valid = 1'b0;
        in_sample = '0;
        in_gain = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_reset_state("por");
        @(negedge clk) rst = 1'b0;

        // Slew from reset: target 0x4000, sample 0x7FFF, SLEW_SHIFT=2 instance.
        for (int c = 0; c < CH; c++) begin
            in_sample[c*W +: W] = 16'h7FFF;
            in_gain[c*GW +: GW] = 16'h4000;
        end
        for (int f = 0; f < 3; f++) begin
            run_frame($sformatf("slew%0d", f));
            check($sformatf("slew%0d_direct", f), 64'(os[1][15:0]), 64'(slew_out[f]));
        end

        // Near-unity gain, no smoothing.
        randomize_frame();
        in_sample[15:0] = 16'h4000;
        in_gain[15:0]   = 16'h7FFF;
        run_frame("unity");
        check("unity_direct", 64'(os[0][15:0]), 64'h3FFF);
        check("unity_flag", 64'(sf[0][0]), 64'd0);

        // Saturation corners, no smoothing.
        randomize_frame();
        in_sample[15:0]  = 16'h8000;
        in_gain[15:0]    = 16'h8000;
        in_sample[31:16] = 16'h7FFF;
        in_gain[31:16]   = 16'h8000;
        run_frame("sat");
        check("sat_pos_clip", 64'(os[0][15:0]), 64'h7FFF);
        check("sat_pos_flag", 64'(sf[0][0]), 64'd1);
        check("sat_neg_noclip", 64'(os[0][31:16]), 64'h8001);
        check("sat_neg_flag", 64'(sf[0][1]), 64'd0);

        for (int n = 0; n < 12; n++) begin
            randomize_frame();
            run_frame($sformatf("rnd%0d", n));
        end

        // Back-to-back: in_valid held high, new random data every cycle.
        acc = 0; nov = 0; last_acc = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            randomize_frame();
            in_valid = 1'b1;
            if (acc > 0)
                check($sformatf("busy_ready_%0d", n), 64'(ir[0]), 64'(n - last_acc >= 8));
            @(posedge clk);
            if (ir[0]) begin
                model_frame();
                acc++;
                last_acc = n;
            end
            #1;
            check($sformatf("busy_valid_%0d", n), 64'(ov[0]), 64'(acc > 0 && n - last_acc == 7));
            if (ov[0]) begin
                nov++;
                check_out($sformatf("busy%0d", nov));
            end
        end
        in_valid = 1'b0;
        check("busy_accepts", 64'(acc), 64'd5);
        check("busy_outputs", 64'(nov), 64'd5);
        repeat (4) @(posedge clk);

        // Reset three cycles into a frame: frame lost, gains restart from zero.
        randomize_frame();
        @(negedge clk) in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check_reset_state($sformatf("midrst%0d", n));
        end
        rst = 1'b0;
        model_reset();
        quiet = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1 if (ov[0] || ov[1] || ov[2]) quiet++;
        end
        check("midrst_no_valid", 64'(quiet), 64'd0);

        randomize_frame();
        for (int c = 0; c < CH; c++) in_gain[c*GW +: GW] = 16'h7FFF;
        in_sample[15:0] = 16'h7FFF;
        run_frame("after_rst");
        check("after_rst_direct", 64'(os[2][15:0]), 64'h07FE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
